// File: rtl/shift_seq_pkg.sv
// Package for the shift command sequencer: data-width helper, default command
// type and pointer-width helper shared by the FIFO and the top level.
package shift_seq_pkg;

    localparam int N_DEFAULT     = 3;
    localparam int DEPTH_DEFAULT = 4;

    // Data width of the shifter for a given shift-amount width.
    function automatic int data_width(input int n);
        return 2 ** n;
    endfunction

    // FIFO pointers carry one extra wrap bit beyond the address bits.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int W_DEFAULT = data_width(N_DEFAULT);
    localparam int PTR_W     = ptr_width(DEPTH_DEFAULT);

    // One buffered shift command at the default geometry.
    typedef struct packed {
        logic [W_DEFAULT-1:0] data;
        logic [N_DEFAULT-1:0] amt;
        logic                 lr;
    } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_fifo.sv
// Synchronous DEPTH-entry command FIFO with a combinational head output.
// Occupancy is tracked with pointers one bit wider than the address, so
// full/empty are distinguished by the wrap bit.
module shift_cmd_fifo
    import shift_seq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = shift_cmd_t
)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Shift command sequencer: buffers {data, amt, lr} commands, presents the head
// to an external combinational shifter and registers its result behind a
// valid/ready output port.
// Optional feature macro: CMD_COUNT_EN adds the 16-bit cmd_count output.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer keeps valid and payload stable until that edge;
// ready may be asserted independently of valid.
module shift_cmd_sequencer
    import shift_seq_pkg::*;
#(
    parameter  int N     = 3,
    parameter  int DEPTH = 4,
    localparam int W     = data_width(N)
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [N-1:0] in_amt,
    input  logic         in_lr,
    output logic [W-1:0] sh_a,
    output logic [N-1:0] sh_amt,
    output logic         sh_lr,
    input  logic [W-1:0] sh_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_lr
`ifdef CMD_COUNT_EN
    ,
    output logic [15:0]  cmd_count
`endif
);

    typedef struct packed {
        logic [W-1:0] data;
        logic [N-1:0] amt;
        logic         lr;
    } cmd_t;

    cmd_t cmd_in;
    cmd_t head;
    logic full;
    logic empty;
    logic advance;

    assign cmd_in   = '{data: in_data, amt: in_amt, lr: in_lr};
    assign in_ready = !full;

    // Move the head through the shifter whenever the result slot is free
    // or is being emptied in this same cycle.
    assign advance  = !empty && (!out_valid || out_ready);

    shift_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data (cmd_in),
        .pop       (advance),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Shifter operands are forced to zero when nothing is queued.
    always_comb begin
        sh_a   = '0;
        sh_amt = '0;
        sh_lr  = 1'b0;
        if (!empty) begin
            sh_a   = head.data;
            sh_amt = head.amt;
            sh_lr  = head.lr;
        end
    end

    // Result register: load on advance, drop valid once consumed with nothing behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lr    <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b1;
            out_data  <= sh_y;
            out_lr    <= head.lr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CMD_COUNT_EN
    // Count completed output handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count <= '0;
        end else if (out_valid && out_ready) begin
            cmd_count <= cmd_count + 16'd1;
        end
    end
`endif

endmodule
